iir_stream_checker: RTL and testbench
=====================================

Name: iir_stream_checker

Overview:
- Self-checking receive end of the IIR filter stream.
- Snoops the sample stream presented to the filter (DUT_VIN/DUT_DIN plus coefficients) and runs a bit-accurate first-order reference model.
- Queues expected results and compares each filter output (VIN/DIN) in order.
- Reports mismatches, unexpected outputs, lost outputs and queue overflow; usable as a synthesizable on-board checker or as a bench sink.

Parameters:
- NB, 12: data and coefficient width, two's complement.
- FRAC, 11: coefficient fractional bits (Q1.11).
- DEPTH, 8: expected-value FIFO depth (power of 2).
- MAX_LAT, 16: max cycles the FIFO head may wait for VIN.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous reset, active-high.
- DUT_VIN  in  1  input sample valid, as seen by the filter.
- DUT_DIN  in  NB  input sample to the filter.
- b0  in  NB  feed-forward coefficient 0.
- b1  in  NB  feed-forward coefficient 1.
- a1  in  NB  feedback coefficient.
- VIN  in  1  filter output valid.
- DIN  in  NB  filter output sample.
- EXP  out  NB  expected value used in the last compare.
- CHK_VALID  out  1  one-cycle pulse per compare.
- MISMATCH  out  1  one-cycle pulse, compare failed.
- ERR  out  4  saturating error count (stops at 15).
- CHK_CNT  out  16  wrapping count of completed compares.
- OVF  out  1  sticky: FIFO overflow.
- TIMEOUT  out  1  sticky: output missing beyond MAX_LAT.

Behaviour:
- Reset: all outputs 0; x_prev, y_prev 0; FIFO empty; FSM IDLE. RST asserted mid-operation clears everything on the next evaluation, independent of CLK.
- Reference model, evaluated on the DUT_VIN cycle:
  - acc = b0*x + b1*x_prev - a1*y_prev, with signed NB*NB products and a 2NB+2-bit accumulator.
  - y = acc arithmetically shifted right by FRAC (truncation toward -inf), saturated to the NB signed range.
  - Coefficients are sampled on the same cycle.
  - x_prev <= x and y_prev <= y (saturated value).
- Latency: y is registered and pushed into the FIFO one cycle after DUT_VIN.
- Compare on VIN: pop the head, EXP <= head, CHK_VALID=1 next cycle, MISMATCH=1 if DIN != head, CHK_CNT+1.
- Bypass: if the FIFO is empty and a push and VIN occur in the same cycle, compare against the pushed value directly; nothing is stored.
- VIN with the FIFO empty and no push: unexpected output. MISMATCH=1, ERR+1, no pop, CHK_CNT unchanged, EXP holds its previous value.
- Push when full with no pop: value dropped, OVF=1, ERR+1.
- Push and pop together when full: both occur, no overflow.
- Watchdog FSM:
  - IDLE (FIFO empty) -> WAIT when the FIFO becomes non-empty; lat_cnt=0.
  - WAIT: lat_cnt increments each cycle without VIN. A pop resets lat_cnt; stay in WAIT if entries remain, else go to IDLE.
  - lat_cnt reaching MAX_LAT: discard the head, TIMEOUT=1, ERR+1, lat_cnt=0, then WAIT or IDLE by fill level.
  - A timeout and a VIN in the same cycle: VIN wins, no timeout.
- ERR increments by at most 1 per cycle. When several error causes occur in one cycle, priority is mismatch/unexpected, then overflow, then timeout. Each sticky flag is still set.

Decomposition:
- Package iir_chk_pkg holds:
  - watchdog FSM state encoding (IDLE, WAIT);
  - ERR saturation limit;
  - helper function sat_nb (saturate an accumulator to NB bits).
- One sub-module: iir_chk_fifo. Synchronous FIFO, DEPTH entries, NB wide, with push/pop/full/empty and simultaneous push/pop when full.
- The model datapath and FSM stay in the top module.

Test Plan:
1. Match: b0=0x400, b1=0x400, a1=0; DUT_DIN 0x200 then 0x200; filter returns 0x100, 0x200 at latency 2 -> two CHK_VALID pulses, EXP=0x100 then 0x200, ERR=0, CHK_CNT=2.
2. Bypass: same coefficients, filter latency 1, output 0x100 -> compare passes with no FIFO write, ERR=0, CHK_CNT=1.
3. Mismatch and unexpected output:
   - as test 1, but second output 0x201 -> MISMATCH pulse, ERR=1;
   - an extra VIN with the FIFO empty -> ERR=2, CHK_CNT unchanged.
4. Saturation: b0=b1=0x7FF, a1=0; inputs 0x7FF, 0x7FF -> EXP 0x7FE, then 0x7FF (clamped from 4092).
5. Overflow and timeout:
   - 9 DUT_VIN with no VIN -> OVF=1 on the 9th push;
   - with no VIN thereafter, entries time out one per MAX_LAT cycles -> TIMEOUT=1, ERR stops at 15.
6. Reset mid-stream: assert RST between two samples -> all outputs 0 immediately; next sample 0x200 gives EXP=0x100 (history cleared).

Source files
------------

// File: rtl/iir_chk_pkg.sv
// iir_chk_pkg: watchdog state encoding, error limit and accumulator saturation for the checker.
package iir_chk_pkg;
    typedef enum logic {IDLE, WAIT} wd_state_t;
    localparam logic [3:0] ERR_MAX = 4'd15;
    function automatic logic signed [63:0] sat_nb(input logic signed [63:0] v, input int nb);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/iir_stream_checker_if.sv
// iir_stream_checker_if: filter input/output snoop signals and checker status.
interface iir_stream_checker_if #(parameter int NB = 12);
    logic          DUT_VIN, VIN, CHK_VALID, MISMATCH, OVF, TIMEOUT;
    logic [NB-1:0] DUT_DIN, b0, b1, a1, DIN, EXP;
    logic [3:0]    ERR;
    logic [15:0]   CHK_CNT;
    modport master (output DUT_VIN, DUT_DIN, b0, b1, a1, VIN, DIN,
                    input  EXP, CHK_VALID, MISMATCH, ERR, CHK_CNT, OVF, TIMEOUT);
    modport slave  (input  DUT_VIN, DUT_DIN, b0, b1, a1, VIN, DIN,
                    output EXP, CHK_VALID, MISMATCH, ERR, CHK_CNT, OVF, TIMEOUT);
endinterface

// File: rtl/iir_chk_fifo.sv
// iir_chk_fifo: expected-value FIFO; a push into a full FIFO is accepted only alongside a pop.
module iir_chk_fifo #(
    parameter int NB    = 12,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [NB-1:0]                din,
    output logic [NB-1:0]                dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [NB-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          wr_en, rd_en;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd];
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    always_ff @(posedge clk)
        if (wr_en) mem[wr] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (wr_en) wr <= wr + AW'(1);
            if (rd_en) rd <= rd + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
endmodule

// File: rtl/iir_stream_checker.sv
// iir_stream_checker: bit-accurate first-order IIR reference model with in-order output compare,
// expected-value queue, latency watchdog and saturating error accounting.
module iir_stream_checker import iir_chk_pkg::*; #(
    parameter int NB      = 12,
    parameter int FRAC    = 11,
    parameter int DEPTH   = 8,
    parameter int MAX_LAT = 16
) (
    input logic                 CLK,
    input logic                 RST,
    iir_stream_checker_if.slave bus
);
    localparam int AW = 2 * NB + 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MAX_LAT + 1);
    logic signed [NB-1:0] x, b0, b1, a1, x_prev, y_reg, y_sat;
    logic signed [AW-1:0] acc;
    logic [NB-1:0]        head, cmp_val;
    logic [CW-1:0]        count, cnt_nxt;
    logic [LW-1:0]        lat_cnt, lat_nxt;
    logic                 push_v, empty, full, avail, mis, tmo, pop, fifo_push, ovf_ev;
    wd_state_t            state, next_state;
    assign x     = $signed(bus.DUT_DIN);
    assign b0    = $signed(bus.b0);
    assign b1    = $signed(bus.b1);
    assign a1    = $signed(bus.a1);
    assign acc   = AW'(b0) * AW'(x) + AW'(b1) * AW'(x_prev) - AW'(a1) * AW'(y_reg);
    assign y_sat = NB'(sat_nb(64'(acc >>> FRAC), NB));
    // y_reg doubles as y_prev: it only changes on a sample, so it always holds the last output
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            x_prev <= '0;
            y_reg  <= '0;
            push_v <= 1'b0;
        end else begin
            push_v <= bus.DUT_VIN;
            if (bus.DUT_VIN) begin
                x_prev <= x;
                y_reg  <= y_sat;
            end
        end
    // An empty queue with a push in flight lets VIN compare against the new value directly
    assign avail     = ~empty | push_v;
    assign cmp_val   = empty ? y_reg : head;
    assign mis       = bus.VIN & (~avail | bus.DIN != cmp_val);
    assign pop       = (bus.VIN & ~empty) | tmo;
    assign fifo_push = push_v & ~(empty & bus.VIN) & (~full | pop);
    assign ovf_ev    = push_v & full & ~pop;
    assign cnt_nxt   = count + CW'(fifo_push) - CW'(pop);
    iir_chk_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
        .clk(CLK), .rst(RST), .push(fifo_push), .pop(pop), .din(y_reg),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= next_state;
            lat_cnt <= lat_nxt;
        end
    always_comb next_state = cnt_nxt != '0 ? WAIT : IDLE;
    always_comb begin
        tmo     = state == WAIT && !bus.VIN && !empty && lat_cnt == LW'(MAX_LAT - 1);
        lat_nxt = (state == IDLE || bus.VIN || tmo) ? '0 : lat_cnt + LW'(1);
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            bus.EXP       <= '0;
            bus.CHK_VALID <= 1'b0;
            bus.MISMATCH  <= 1'b0;
            bus.ERR       <= '0;
            bus.CHK_CNT   <= '0;
            bus.OVF       <= 1'b0;
            bus.TIMEOUT   <= 1'b0;
        end else begin
            bus.CHK_VALID <= bus.VIN & avail;
            bus.MISMATCH  <= mis;
            if (bus.VIN && avail) begin
                bus.EXP     <= cmp_val;
                bus.CHK_CNT <= bus.CHK_CNT + 16'd1;
            end
            if ((mis || ovf_ev || tmo) && bus.ERR != ERR_MAX) bus.ERR <= bus.ERR + 4'd1;
            if (ovf_ev) bus.OVF <= 1'b1;
            if (tmo) bus.TIMEOUT <= 1'b1;
        end
endmodule

// File: tb/tb_iir_stream_checker.sv
// tb_iir_stream_checker: directed plan scenarios plus a randomized stream scored against an integer IIR model.
module tb_iir_stream_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   xp, yp, nbad, nchk;
    typedef struct { logic [11:0] y; int due; } exp_t;
    exp_t q[$];
    exp_t cur;
    logic vin, bad, dv;
    iir_stream_checker_if #(.NB(12)) bus();
    iir_stream_checker #(.NB(12), .FRAC(11), .DEPTH(8), .MAX_LAT(16)) dut (.CLK(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dvin, input logic [11:0] dd, input logic v, input logic [11:0] d);
        bus.DUT_VIN = dvin;
        bus.DUT_DIN = dd;
        bus.VIN     = v;
        bus.DIN     = d;
    endtask

    task automatic coef(input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2);
        bus.b0 = c0;
        bus.b1 = c1;
        bus.a1 = c2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 12'h0, 1'b0, 12'h0);
        tick();
        tick();
        rst = 1'b0;
        xp = 0;
        yp = 0;
        q.delete();
    endtask

    function automatic int sx(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    // Plain-integer reference: floor division by 2^11 then clamp to 12-bit signed
    function automatic logic [11:0] ref_y(input logic [11:0] c0, input logic [11:0] c1,
                                          input logic [11:0] c2, input logic [11:0] xv);
        int acc, y;
        acc = sx(c0) * sx(xv) + sx(c1) * xp - sx(c2) * yp;
        y   = acc >>> 11;
        y   = y > 2047 ? 2047 : (y < -2048 ? -2048 : y);
        xp  = sx(xv);
        yp  = y;
        return 12'(y);
    endfunction

    initial begin
        coef(12'h0, 12'h0, 12'h0);
        do_reset();
        chk("rst_exp", 32'(bus.EXP), 0);
        chk("rst_flags", {bus.CHK_VALID, bus.MISMATCH, bus.OVF, bus.TIMEOUT}, 0);
        chk("rst_cnt", {bus.ERR, bus.CHK_CNT}, 0);

        // match at latency 2
        coef(12'h400, 12'h400, 12'h0);
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b0, 12'h0, 1'b1, 12'h100); tick();
        chk("m_valid0", bus.CHK_VALID, 1);
        chk("m_exp0", 32'(bus.EXP), 32'h100);
        chk("m_mis0", bus.MISMATCH, 0);
        drive(1'b0, 12'h0, 1'b1, 12'h200); tick();
        chk("m_exp1", 32'(bus.EXP), 32'h200);
        chk("m_mis1", bus.MISMATCH, 0);
        drive(1'b0, 12'h0, 1'b0, 12'h0); tick();
        chk("m_valid_end", bus.CHK_VALID, 0);
        chk("m_err", 32'(bus.ERR), 0);
        chk("m_cnt", 32'(bus.CHK_CNT), 2);

        // bypass at latency 1, then an extra VIN proves nothing was stored
        do_reset();
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b0, 12'h0, 1'b1, 12'h100); tick();
        chk("b_valid", bus.CHK_VALID, 1);
        chk("b_exp", 32'(bus.EXP), 32'h100);
        chk("b_mis", bus.MISMATCH, 0);
        drive(1'b0, 12'h0, 1'b1, 12'h100); tick();
        chk("b_unexp_mis", bus.MISMATCH, 1);
        chk("b_unexp_valid", bus.CHK_VALID, 0);
        chk("b_cnt", 32'(bus.CHK_CNT), 1);
        chk("b_err", 32'(bus.ERR), 1);

        // mismatch then unexpected output
        do_reset();
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b0, 12'h0, 1'b1, 12'h100); tick();
        chk("x_mis0", bus.MISMATCH, 0);
        drive(1'b0, 12'h0, 1'b1, 12'h201); tick();
        chk("x_mis1", bus.MISMATCH, 1);
        chk("x_exp1", 32'(bus.EXP), 32'h200);
        chk("x_err1", 32'(bus.ERR), 1);
        drive(1'b0, 12'h0, 1'b0, 12'h0); tick();
        chk("x_pulse", bus.MISMATCH, 0);
        drive(1'b0, 12'h0, 1'b1, 12'h55); tick();
        chk("x_unexp", bus.MISMATCH, 1);
        chk("x_err2", 32'(bus.ERR), 2);
        chk("x_cnt", 32'(bus.CHK_CNT), 2);
        chk("x_exp_hold", 32'(bus.EXP), 32'h200);

        // saturation
        do_reset();
        coef(12'h7FF, 12'h7FF, 12'h0);
        drive(1'b1, 12'h7FF, 1'b0, 12'h0); tick();
        drive(1'b1, 12'h7FF, 1'b0, 12'h0); tick();
        drive(1'b0, 12'h0, 1'b1, 12'h7FE); tick();
        chk("s_exp0", 32'(bus.EXP), 32'h7FE);
        drive(1'b0, 12'h0, 1'b1, 12'h7FF); tick();
        chk("s_exp1", 32'(bus.EXP), 32'h7FF);
        chk("s_err", 32'(bus.ERR), 0);

        // overflow on the 9th push, then timeouts every 16 cycles, then ERR saturation
        do_reset();
        coef(12'h400, 12'h400, 12'h0);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 12'h010, 1'b0, 12'h0);
            tick();
        end
        chk("o_pre", bus.OVF, 0);
        drive(1'b0, 12'h0, 1'b0, 12'h0); tick();
        chk("o_ovf", bus.OVF, 1);
        chk("o_err", 32'(bus.ERR), 1);
        for (int k = 11; k <= 17; k++) tick();
        chk("t_pre", bus.TIMEOUT, 0);
        tick();
        chk("t_first", bus.TIMEOUT, 1);
        chk("t_err2", 32'(bus.ERR), 2);
        for (int k = 19; k <= 129; k++) tick();
        chk("t_err8", 32'(bus.ERR), 8);
        tick();
        tick();
        chk("t_err9", 32'(bus.ERR), 9);
        chk("t_sticky", {bus.OVF, bus.TIMEOUT}, 2'b11);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 12'h0, 1'b1, 12'h0);
            tick();
        end
        drive(1'b0, 12'h0, 1'b0, 12'h0); tick();
        chk("t_err_sat", 32'(bus.ERR), 15);
        chk("t_cnt", 32'(bus.CHK_CNT), 0);

        // asynchronous reset mid-stream clears history and queue
        do_reset();
        coef(12'h400, 12'h400, 12'h0);
        drive(1'b1, 12'h300, 1'b0, 12'h0); tick();
        drive(1'b1, 12'h300, 1'b1, 12'h180); tick();
        chk("r_exp_pre", 32'(bus.EXP), 32'h180);
        drive(1'b0, 12'h0, 1'b0, 12'h0); tick();
        rst = 1'b1;
        #1;
        chk("r_async_exp", 32'(bus.EXP), 0);
        chk("r_async_cnt", {bus.ERR, bus.CHK_CNT}, 0);
        chk("r_async_flags", {bus.CHK_VALID, bus.MISMATCH, bus.OVF, bus.TIMEOUT}, 0);
        #1;
        rst = 1'b0;
        drive(1'b1, 12'h200, 1'b0, 12'h0); tick();
        drive(1'b0, 12'h0, 1'b1, 12'h100); tick();
        chk("r_exp_post", 32'(bus.EXP), 32'h100);
        chk("r_mis_post", bus.MISMATCH, 0);
        chk("r_cnt_post", 32'(bus.CHK_CNT), 1);

        // randomized stream, filter latency 2, occasional corrupted output
        do_reset();
        nbad = 0;
        nchk = 0;
        for (int c = 0; c < 304; c++) begin
            dv = (c < 300) && ($urandom_range(2, 0) != 0);
            bus.DUT_VIN = dv;
            if (dv) begin
                coef(12'($urandom), 12'($urandom), 12'($urandom));
                bus.DUT_DIN = 12'($urandom);
                cur.y   = ref_y(bus.b0, bus.b1, bus.a1, bus.DUT_DIN);
                cur.due = c + 2;
                q.push_back(cur);
            end
            vin = q.size() > 0 && q[0].due == c;
            bad = 1'b0;
            if (vin) begin
                cur = q.pop_front();
                bad = $urandom_range(15, 0) == 0;
            end
            bus.VIN = vin;
            bus.DIN = vin ? cur.y ^ {11'h0, bad} : 12'h0;
            tick();
            chk("rnd_valid", bus.CHK_VALID, vin);
            if (vin) begin
                chk("rnd_exp", 32'(bus.EXP), 32'(cur.y));
                chk("rnd_mis", bus.MISMATCH, bad);
                nchk++;
                nbad += bad;
            end
        end
        chk("rnd_err", 32'(bus.ERR), nbad > 15 ? 15 : nbad);
        chk("rnd_cnt", 32'(bus.CHK_CNT), nchk);
        chk("rnd_flags", {bus.OVF, bus.TIMEOUT}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
